// File: rtl/dekatron_chain_ctrl.sv
// Sequencer for a chain of dekatron counting tubes: steps digits with carry/borrow and keeps a one-hot shadow of each tube.
// Optional macro DEKATRON_CHAIN_OVERFLOW_EN enables the Overflow flag; otherwise the chain wraps silently.
module dekatron_chain_ctrl #(
    parameter int DIGITS        = 3,
    parameter int PULSE_WIDTH   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req,
    input  logic                   ReqDir,
    input  logic                   Clr,
    output logic [DIGITS-1:0]      Step,
    output logic                   Dir,
    output logic                   DekRst,
    output logic [10*DIGITS-1:0]   Out,
    output logic                   Busy,
    output logic                   Ack,
    output logic                   Overflow
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(PULSE_WIDTH + SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(PULSE_WIDTH + SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LEN   = CNT_W'(PULSE_WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        CLEAR,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS-1:0][9:0]  shadow;
    logic                    wrapped;
    logic [9:0]              cur_digit;
    logic [9:0]              rot_digit;
    logic                    cur_wraps;
    logic                    accept;
    logic                    last_pulse;
    logic                    settle_done;

    assign accept      = (state == IDLE) && (Req || Clr);
    assign last_pulse  = (state == PULSE) && (cnt == PULSE_LAST);
    assign settle_done = (state == SETTLE) && (cnt == SETTLE_LAST);
    assign Out         = shadow;

    // A wrap is detected from the position the digit leaves, before it rotates.
    always_comb begin
        cur_digit = shadow[idx];
        rot_digit = Dir ? {cur_digit[0], cur_digit[9:1]} : {cur_digit[8:0], cur_digit[9]};
        cur_wraps = Dir ? cur_digit[0] : cur_digit[9];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        Step       = '0;
        DekRst     = 1'b0;
        Busy       = (state != IDLE);
        Ack        = (state == DONE);
        case (state)
            IDLE: begin
                if (Clr) begin
                    next_state = CLEAR;
                end else if (Req) begin
                    next_state = PULSE;
                end
            end
            PULSE: begin
                Step[idx] = 1'b1;
                if (last_pulse) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    next_state = (wrapped && (idx != TOP_IDX)) ? PULSE : DONE;
                end
            end
            CLEAR: begin
                DekRst = (cnt < PULSE_LEN);
                if (cnt == CLEAR_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The phase counter restarts on every state change, including SETTLE back into PULSE for a carry.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt     <= '0;
            idx     <= '0;
            Dir     <= 1'b0;
            wrapped <= 1'b0;
            shadow  <= {DIGITS{10'd1}};
        end else begin
            cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);
            if ((state == IDLE) && Clr) begin
                shadow <= {DIGITS{10'd1}};
            end else if ((state == IDLE) && Req) begin
                Dir <= ReqDir;
                idx <= '0;
            end
            if (last_pulse) begin
                shadow[idx] <= rot_digit;
                wrapped     <= cur_wraps;
            end
            if (settle_done && wrapped && (idx != TOP_IDX)) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef DEKATRON_CHAIN_OVERFLOW_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Overflow <= 1'b0;
        end else if (accept) begin
            Overflow <= 1'b0;
        end else if (settle_done && wrapped && (idx == TOP_IDX)) begin
            Overflow <= 1'b1;
        end
    end
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dekatron_chain_ctrl.sv
// Directed scoreboard bench for dekatron_chain_ctrl (DIGITS=3, PULSE_WIDTH=4, SETTLE_CYCLES=2).
module tb_dekatron_chain_ctrl;

    localparam int DIGITS = 3;
    localparam int PW     = 4;
    localparam int SC     = 2;
    localparam int OP     = PW + SC;
`ifdef DEKATRON_CHAIN_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Req = 1'b0;
    logic              ReqDir = 1'b0;
    logic              Clr = 1'b0;
    logic [DIGITS-1:0] Step;
    logic              Dir;
    logic              DekRst;
    logic [29:0]       Out;
    logic              Busy;
    logic              Ack;
    logic              Overflow;

    typedef struct {
        logic [29:0] out;
        int          ack;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [2:0]  step_log[64];
    logic        dek_log[64];
    logic        dir_log[64];
    logic [29:0] out_at_ack;
    logic        ovf_at_ack;
    bit          ack_seen;
    int          ack_rel;

    dekatron_chain_ctrl #(
        .DIGITS(DIGITS),
        .PULSE_WIDTH(PW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Req(Req),
        .ReqDir(ReqDir),
        .Clr(Clr),
        .Step(Step),
        .Dir(Dir),
        .DekRst(DekRst),
        .Out(Out),
        .Busy(Busy),
        .Ack(Ack),
        .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model: decimal value to the expected one-hot shadow vector.
    function automatic logic [29:0] shadow_of(input int v);
        logic [29:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[10*d + (v / p) % 10] = 1'b1;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic issue(input logic req, input logic dir, input logic clr, output int acc);
        @(negedge Clk);
        Req = req;
        ReqDir = dir;
        Clr = clr;
        acc = cyc;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        Clr = 1'b0;
    endtask

    task automatic wait_ack(input int acc);
        int rel;
        ack_seen = 1'b0;
        ack_rel = -1;
        for (int i = 0; i < 64; i++) begin
            step_log[i] = '0;
            dek_log[i] = 1'b0;
            dir_log[i] = 1'b0;
        end
        for (int i = 0; i < 60 && !ack_seen; i++) begin
            @(negedge Clk);
            rel = cyc - acc;
            if (rel >= 0 && rel < 64) begin
                step_log[rel] = Step;
                dek_log[rel] = DekRst;
                dir_log[rel] = Dir;
            end
            if (Ack) begin
                ack_seen = 1'b1;
                ack_rel = rel;
                out_at_ack = Out;
                ovf_at_ack = Overflow;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Out !== shadow_of(0)) begin
            errors++;
            $display("[TB] FAIL reset_out: got %h expected %h", Out, shadow_of(0));
        end
        checks++;
        if ({Step, Busy, Ack, Dir, DekRst, Overflow} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got step=%b busy=%b ack=%b dir=%b dekrst=%b ovf=%b expected all 0", Step, Busy, Ack, Dir, DekRst, Overflow);
        end
        Rst = 1'b0;
    endtask

    task automatic test_single_inc();
        int acc;
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, acc);
        e.out = shadow_of(1); e.ack = 1 + OP; e.ovf = 1'b0;
        sb.push_back(e);
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL single_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL single_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL single_out: got %h expected %h", out_at_ack, e.out); end
            for (int r = 1; r <= OP; r++) begin
                logic [2:0] ex;
                ex = (r <= PW) ? 3'b001 : 3'b000;
                checks++;
                if (step_log[r] !== ex) begin errors++; $display("[TB] FAIL single_step c%0d: got %b expected %b", r, step_log[r], ex); end
            end
        end
    endtask

    task automatic test_carry();
        int acc;
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            issue(1'b1, 1'b0, 1'b0, acc);
            wait_ack(acc);
        end
        issue(1'b1, 1'b0, 1'b0, acc);
        e.out = shadow_of(10); e.ack = 1 + 2*OP; e.ovf = 1'b0;
        sb.push_back(e);
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL carry_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL carry_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL carry_out: got %h expected %h", out_at_ack, e.out); end
            for (int r = 1; r <= 2*OP; r++) begin
                logic [2:0] ex;
                ex = (((r-1) % OP) < PW) ? 3'(1 << ((r-1) / OP)) : 3'b000;
                checks++;
                if (step_log[r] !== ex) begin errors++; $display("[TB] FAIL carry_step c%0d: got %b expected %b", r, step_log[r], ex); end
            end
        end
    endtask

    task automatic test_decrement();
        int acc;
        exp_t e;
        issue(1'b0, 1'b0, 1'b1, acc);
        wait_ack(acc);
        issue(1'b1, 1'b1, 1'b0, acc);
        e.out = shadow_of(999); e.ack = 1 + 3*OP; e.ovf = OVF_EN;
        sb.push_back(e);
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL dec_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL dec_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL dec_out: got %h expected %h", out_at_ack, e.out); end
            checks++;
            if (ovf_at_ack !== e.ovf) begin errors++; $display("[TB] FAIL dec_ovf: got %b expected %b", ovf_at_ack, e.ovf); end
            for (int r = 1; r <= 3*OP; r++) begin
                logic [2:0] ex;
                ex = (((r-1) % OP) < PW) ? 3'(1 << ((r-1) / OP)) : 3'b000;
                checks++;
                if (step_log[r] !== ex || dir_log[r] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL dec_step c%0d: got step=%b dir=%b expected step=%b dir=1", r, step_log[r], dir_log[r], ex);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int acc;
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, acc);
        e.out = shadow_of(0); e.ack = 1 + 3*OP; e.ovf = OVF_EN;
        sb.push_back(e);
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL ovf_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL ovf_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL ovf_out: got %h expected %h", out_at_ack, e.out); end
            checks++;
            if (ovf_at_ack !== e.ovf) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected %b", ovf_at_ack, e.ovf); end
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (Overflow !== OVF_EN) begin errors++; $display("[TB] FAIL ovf_hold: got %b expected %b", Overflow, OVF_EN); end
    endtask

    task automatic test_clr_priority();
        int acc;
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, acc);
        wait_ack(acc);
        issue(1'b1, 1'b0, 1'b1, acc);
        e.out = shadow_of(0); e.ack = 1 + OP; e.ovf = 1'b0;
        sb.push_back(e);
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL clr_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL clr_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL clr_out: got %h expected %h", out_at_ack, e.out); end
            checks++;
            if (ovf_at_ack !== e.ovf) begin errors++; $display("[TB] FAIL clr_ovf: got %b expected %b", ovf_at_ack, e.ovf); end
            for (int r = 1; r <= OP; r++) begin
                logic ex;
                ex = (r <= PW);
                checks++;
                if (dek_log[r] !== ex || step_log[r] !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL clr_seq c%0d: got dekrst=%b step=%b expected dekrst=%b step=000", r, dek_log[r], step_log[r], ex);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int acc;
        int stray;
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, acc);
        wait_ack(acc);
        issue(1'b1, 1'b0, 1'b0, acc);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (Step !== 3'b000 || Busy !== 1'b0 || Out !== shadow_of(0)) begin
            errors++;
            $display("[TB] FAIL abort_state: got step=%b busy=%b out=%h expected step=000 busy=0 out=%h", Step, Busy, Out, shadow_of(0));
        end
        Rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Ack) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("[TB] FAIL abort_ack: got %0d Ack cycles expected 0", stray); end

        issue(1'b1, 1'b0, 1'b0, acc);
        e.out = shadow_of(1); e.ack = 1 + OP; e.ovf = 1'b0;
        sb.push_back(e);
        @(negedge Clk);
        Req = 1'b1;
        ReqDir = 1'b1;
        @(negedge Clk);
        Req = 1'b0;
        wait_ack(acc);
        e = sb.pop_front();
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("[TB] FAIL busy_ack: no Ack within 60 cycles, expected cycle %0d", e.ack);
        end else begin
            if (ack_rel !== e.ack) begin errors++; $display("[TB] FAIL busy_ack: got cycle %0d expected %0d", ack_rel, e.ack); end
            checks++;
            if (out_at_ack !== e.out) begin errors++; $display("[TB] FAIL busy_out: got %h expected %h", out_at_ack, e.out); end
        end
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if (Ack || Busy) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("[TB] FAIL busy_queue: got %0d busy/ack cycles expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_carry();
        test_decrement();
        test_overflow();
        test_clr_priority();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
